depth_test: RTL and testbench
=============================

DEPTH_TEST -- requirements
Module: depth_test

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 15, frame/depth buffer address width.
REQ-002 SHALL have parameter DEPTH_WIDTH, default 16, signed fragment depth width.
REQ-003 SHALL have parameter COLOR_WIDTH, default 12, fragment colour width.
REQ-004 SHALL have parameter FB_SIZE, default 19200 (160x120), number of valid pixel addresses.
REQ-005 SHALL have ports, in this order:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- clear_start  in  1  one-cycle pulse requesting a depth-buffer clear.
- clear_busy  out  1  high while a clear is pending or running.
- frag_valid  in  1  fragment present.
- frag_ready  out  1  fragment accepted when frag_valid and frag_ready are both high.
- frag_addr  in  ADDR_WIDTH  pixel address.
- frag_depth  in  DEPTH_WIDTH  signed depth; smaller is nearer.
- frag_color  in  COLOR_WIDTH  pixel colour.
- zb_rd_addr  out  ADDR_WIDTH  depth RAM read address, combinational.
- zb_rd_data  in  DEPTH_WIDTH  depth RAM data, one-cycle latency, read-old-on-collision.
- zb_we  out  1  depth RAM write enable.
- zb_wr_addr  out  ADDR_WIDTH  depth RAM write address.
- zb_wr_data  out  DEPTH_WIDTH  depth RAM write data.
- fb_we  out  1  colour buffer write enable.
- fb_addr  out  ADDR_WIDTH  colour buffer write address.
- fb_color  out  COLOR_WIDTH  colour buffer write data.
- pass_count  out  32  fragments written since last clear.

Function
REQ-006 SHALL implement states IDLE, RUN, DRAIN, CLEAR.
REQ-007 IDLE->RUN on first accepted fragment; RUN->IDLE when the pipeline is empty and frag_valid is low.
REQ-008 A clear_start in IDLE or RUN SHALL be latched as pending and raise clear_busy the next cycle.
REQ-009 With a clear pending, the FSM SHALL enter DRAIN, drop frag_ready, and move to CLEAR once the pipeline is empty.
REQ-010 A fragment offered in the same cycle as clear_start SHALL be accepted.
REQ-011 clear_start during DRAIN or CLEAR SHALL be ignored.
REQ-012 In CLEAR the block SHALL write the depth value 0x7FFF (signed DEPTH_WIDTH max) to addresses 0..FB_SIZE-1, one per cycle, ascending, with fb_we low.
REQ-013 After writing address FB_SIZE-1 the block SHALL clear pass_count to 0 and drop clear_busy the same cycle, returning to IDLE.
REQ-014 frag_ready SHALL be high in IDLE and RUN with no clear pending, and low otherwise; the pipeline SHALL never stall once a fragment is accepted.
REQ-015 Pipeline stage S0 (accept cycle N): zb_rd_addr = frag_addr; capture addr, depth and colour.
REQ-016 Stage S1 (cycle N+1): compare frag_depth < stored depth (signed, strict); equal depth SHALL fail.
REQ-017 Stage S2 (cycle N+2): on pass, assert zb_we and fb_we together for exactly one cycle with the registered addr, depth and colour; pass_count increments by 1.
REQ-018 Stored-depth forwarding SHALL apply in S1 with this priority: S2 write this cycle to the same address, then the write one cycle earlier to the same address, then zb_rd_data.
REQ-019 Fragments with frag_addr >= FB_SIZE SHALL be accepted and discarded with no write.
REQ-020 pass_count SHALL saturate at 0xFFFFFFFF.

Reset
REQ-021 rst SHALL take effect at the next clock edge and override all other inputs.
REQ-022 Reset SHALL bring: state IDLE; clear pending and clear_busy low; all pipeline stages empty; zb_we and fb_we low; zb_wr_addr, zb_wr_data, fb_addr, fb_color, pass_count 0; frag_ready high from the first cycle after reset.
REQ-023 Reset mid-clear or mid-pipeline SHALL abandon outstanding work with no further writes.

Structure
REQ-024 The state enum and the DEPTH_CLEAR_VALUE constant SHALL live in the shared render-pipeline package.
REQ-025 The S1/S2 compare-forward datapath SHALL be one sub-module, depth_compare_stage; the FSM and clear counter SHALL stay in depth_test.

Verification
REQ-026 Single fragment, addr 100, depth 50, RAM value 0x7FFF: zb_we and fb_we high at N+2 with addr 100, data 50; pass_count=1.
REQ-027 Back-to-back fragments, addr 7, depths 40 then 30, RAM 0x7FFF: both written; then depth 35 at addr 7 is rejected by forwarded 30.
REQ-028 Equal depth: RAM 20, fragment depth 20: no write, pass_count unchanged.
REQ-029 clear_start with 2 fragments in flight: both complete; then exactly 19200 zb writes of 0x7FFF to 0..19199; frag_ready low throughout; pass_count=0.
REQ-030 Fragment addr 19200: no write, frag_ready stays high.
REQ-031 rst asserted at clear address 500: no zb_we after reset; clear_busy low and frag_ready high on the following cycle.

Source files
------------

// File: rtl/depth_test_pkg.sv
// Shared render-pipeline definitions used by the depth-test block and its datapath.
package depth_test_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_CLEAR
    } dt_state_e;

    localparam int unsigned PASS_COUNT_WIDTH = 32;

    // Signed maximum, left-aligned in 64 bits; shift right by (64 - width) to narrow it.
    localparam logic [63:0] DEPTH_CLEAR_VALUE = 64'h7FFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/depth_test_if.sv
// Fragment, clear-control, depth-RAM and colour-buffer signals of the depth-test block.
interface depth_test_if
    import depth_test_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 15,
    parameter int unsigned DEPTH_WIDTH = 16,
    parameter int unsigned COLOR_WIDTH = 12
);
    logic                        clear_start;
    logic                        clear_busy;
    logic                        frag_valid;
    logic                        frag_ready;
    logic [ADDR_WIDTH-1:0]       frag_addr;
    logic [DEPTH_WIDTH-1:0]      frag_depth;
    logic [COLOR_WIDTH-1:0]      frag_color;
    logic [ADDR_WIDTH-1:0]       zb_rd_addr;
    logic [DEPTH_WIDTH-1:0]      zb_rd_data;
    logic                        zb_we;
    logic [ADDR_WIDTH-1:0]       zb_wr_addr;
    logic [DEPTH_WIDTH-1:0]      zb_wr_data;
    logic                        fb_we;
    logic [ADDR_WIDTH-1:0]       fb_addr;
    logic [COLOR_WIDTH-1:0]      fb_color;
    logic [PASS_COUNT_WIDTH-1:0] pass_count;

    modport master (
        output clear_start, frag_valid, frag_addr, frag_depth, frag_color, zb_rd_data,
        input  clear_busy, frag_ready, zb_rd_addr, zb_we, zb_wr_addr, zb_wr_data,
               fb_we, fb_addr, fb_color, pass_count
    );

    modport slave (
        input  clear_start, frag_valid, frag_addr, frag_depth, frag_color, zb_rd_data,
        output clear_busy, frag_ready, zb_rd_addr, zb_we, zb_wr_addr, zb_wr_data,
               fb_we, fb_addr, fb_color, pass_count
    );

endinterface

// File: rtl/depth_compare_stage.sv
// S1 capture and strict signed depth compare, forwarding the two most recent depth writes.
module depth_compare_stage #(
    parameter int unsigned ADDR_WIDTH  = 15,
    parameter int unsigned DEPTH_WIDTH = 16,
    parameter int unsigned COLOR_WIDTH = 12,
    parameter int unsigned FB_SIZE     = 19200
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   accept,
    input  logic [ADDR_WIDTH-1:0]  frag_addr,
    input  logic [DEPTH_WIDTH-1:0] frag_depth,
    input  logic [COLOR_WIDTH-1:0] frag_color,
    input  logic [DEPTH_WIDTH-1:0] rd_data,
    input  logic                   cur_we,
    input  logic [ADDR_WIDTH-1:0]  cur_addr,
    input  logic [DEPTH_WIDTH-1:0] cur_data,
    output logic                   s1_valid,
    output logic [ADDR_WIDTH-1:0]  s1_addr,
    output logic [DEPTH_WIDTH-1:0] s1_depth,
    output logic [COLOR_WIDTH-1:0] s1_color,
    output logic                   pass_c
);
    logic                   prev_we;
    logic [ADDR_WIDTH-1:0]  prev_addr;
    logic [DEPTH_WIDTH-1:0] prev_data;
    logic [DEPTH_WIDTH-1:0] stored_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_addr   <= '0;
            s1_depth  <= '0;
            s1_color  <= '0;
            prev_we   <= 1'b0;
            prev_addr <= '0;
            prev_data <= '0;
        end else begin
            s1_valid  <= accept;
            if (accept) begin
                s1_addr  <= frag_addr;
                s1_depth <= frag_depth;
                s1_color <= frag_color;
            end
            prev_we   <= cur_we;
            prev_addr <= cur_addr;
            prev_data <= cur_data;
        end
    end

    // The RAM returns old data for writes landing this cycle or last cycle, so newest write wins.
    always_comb begin
        stored_c = rd_data;
        if (prev_we && (prev_addr == s1_addr)) stored_c = prev_data;
        if (cur_we && (cur_addr == s1_addr))   stored_c = cur_data;
        pass_c = s1_valid && (32'(s1_addr) < FB_SIZE) &&
                 ($signed(s1_depth) < $signed(stored_c));
    end

endmodule

// File: rtl/depth_test.sv
// Depth-test pipeline with a drain-then-clear sequencer for the depth buffer.
module depth_test
    import depth_test_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 15,
    parameter int unsigned DEPTH_WIDTH = 16,
    parameter int unsigned COLOR_WIDTH = 12,
    parameter int unsigned FB_SIZE     = 19200
) (
    input  logic         clk,
    input  logic         rst,
    depth_test_if.slave  bus
);
    localparam logic [DEPTH_WIDTH-1:0] CLEAR_DEPTH = DEPTH_WIDTH'(DEPTH_CLEAR_VALUE >> (64 - DEPTH_WIDTH));
    localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR   = ADDR_WIDTH'(FB_SIZE - 1);

    dt_state_e                   state, state_d;
    logic [ADDR_WIDTH-1:0]       clr_addr, clr_addr_d;
    logic                        clear_busy_d, frag_ready_d;
    logic                        zb_we_d, fb_we_d;
    logic [ADDR_WIDTH-1:0]       zb_wr_addr_d, fb_addr_d;
    logic [DEPTH_WIDTH-1:0]      zb_wr_data_d;
    logic [COLOR_WIDTH-1:0]      fb_color_d;
    logic [PASS_COUNT_WIDTH-1:0] pass_count_d;

    logic                        accept_c, pipe_empty_c, s1_valid, pass_c;
    logic [ADDR_WIDTH-1:0]       s1_addr;
    logic [DEPTH_WIDTH-1:0]      s1_depth;
    logic [COLOR_WIDTH-1:0]      s1_color;

    assign bus.zb_rd_addr = bus.frag_addr;
    assign accept_c       = bus.frag_valid && bus.frag_ready;
    assign pipe_empty_c   = !s1_valid && !bus.zb_we;

    depth_compare_stage #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH_WIDTH(DEPTH_WIDTH),
        .COLOR_WIDTH(COLOR_WIDTH),
        .FB_SIZE    (FB_SIZE)
    ) u_cmp (
        .clk       (clk),
        .rst       (rst),
        .accept    (accept_c),
        .frag_addr (bus.frag_addr),
        .frag_depth(bus.frag_depth),
        .frag_color(bus.frag_color),
        .rd_data   (bus.zb_rd_data),
        .cur_we    (bus.zb_we),
        .cur_addr  (bus.zb_wr_addr),
        .cur_data  (bus.zb_wr_data),
        .s1_valid  (s1_valid),
        .s1_addr   (s1_addr),
        .s1_depth  (s1_depth),
        .s1_color  (s1_color),
        .pass_c    (pass_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            clr_addr       <= '0;
            bus.clear_busy <= 1'b0;
            bus.frag_ready <= 1'b1;
            bus.zb_we      <= 1'b0;
            bus.zb_wr_addr <= '0;
            bus.zb_wr_data <= '0;
            bus.fb_we      <= 1'b0;
            bus.fb_addr    <= '0;
            bus.fb_color   <= '0;
            bus.pass_count <= '0;
        end else begin
            state          <= state_d;
            clr_addr       <= clr_addr_d;
            bus.clear_busy <= clear_busy_d;
            bus.frag_ready <= frag_ready_d;
            bus.zb_we      <= zb_we_d;
            bus.zb_wr_addr <= zb_wr_addr_d;
            bus.zb_wr_data <= zb_wr_data_d;
            bus.fb_we      <= fb_we_d;
            bus.fb_addr    <= fb_addr_d;
            bus.fb_color   <= fb_color_d;
            bus.pass_count <= pass_count_d;
        end
    end

    // Next state plus the S2 / clear write port; write data holds when nothing is written.
    always_comb begin
        state_d      = state;
        clr_addr_d   = clr_addr;
        clear_busy_d = bus.clear_busy;
        zb_we_d      = pass_c;
        fb_we_d      = pass_c;
        zb_wr_addr_d = bus.zb_wr_addr;
        zb_wr_data_d = bus.zb_wr_data;
        fb_addr_d    = bus.fb_addr;
        fb_color_d   = bus.fb_color;
        pass_count_d = bus.pass_count;

        if (pass_c) begin
            zb_wr_addr_d = s1_addr;
            zb_wr_data_d = s1_depth;
            fb_addr_d    = s1_addr;
            fb_color_d   = s1_color;
            if (bus.pass_count != '1) pass_count_d = bus.pass_count + 32'd1;
        end

        case (state)
            ST_IDLE: begin
                if (bus.clear_start) begin
                    state_d      = ST_DRAIN;
                    clear_busy_d = 1'b1;
                end else if (accept_c) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.clear_start) begin
                    state_d      = ST_DRAIN;
                    clear_busy_d = 1'b1;
                end else if (!bus.frag_valid && pipe_empty_c) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (pipe_empty_c) begin
                    state_d    = ST_CLEAR;
                    clr_addr_d = '0;
                end
            end
            ST_CLEAR: begin
                zb_we_d      = 1'b1;
                fb_we_d      = 1'b0;
                zb_wr_addr_d = clr_addr;
                zb_wr_data_d = CLEAR_DEPTH;
                if (clr_addr == LAST_ADDR) begin
                    state_d      = ST_IDLE;
                    clear_busy_d = 1'b0;
                    pass_count_d = '0;
                end else begin
                    clr_addr_d = clr_addr + ADDR_WIDTH'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        frag_ready_d = ((state_d == ST_IDLE) || (state_d == ST_RUN)) && !clear_busy_d;
    end

endmodule

// File: tb/tb_depth_test.sv
// Directed bench for depth_test with a read-old-on-collision depth RAM model.
module tb_depth_test;
    localparam int unsigned AW = 15;
    localparam int unsigned DW = 16;
    localparam int unsigned CW = 12;
    localparam int unsigned FB = 19200;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    depth_test_if #(.ADDR_WIDTH(AW), .DEPTH_WIDTH(DW), .COLOR_WIDTH(CW)) bus ();

    depth_test #(.ADDR_WIDTH(AW), .DEPTH_WIDTH(DW), .COLOR_WIDTH(CW), .FB_SIZE(FB)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [DW-1:0] mem [FB];
    logic          fill_en, poke_en;
    logic [AW-1:0] poke_addr;
    logic [DW-1:0] poke_data;

    always @(posedge clk) begin
        if (fill_en) begin
            for (int i = 0; i < int'(FB); i++) mem[i] <= 16'h7FFF;
        end else if (poke_en) begin
            mem[poke_addr] <= poke_data;
        end else if (bus.zb_we && (32'(bus.zb_wr_addr) < FB)) begin
            mem[bus.zb_wr_addr] <= bus.zb_wr_data;
        end
        bus.zb_rd_data <= (32'(bus.zb_rd_addr) < FB) ? mem[bus.zb_rd_addr] : 16'h0000;
    end

    int total = 0;
    int bad   = 0;
    int exp_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [CW-1:0] c);
        bus.frag_valid = v;
        bus.frag_addr  = a;
        bus.frag_depth = d;
        bus.frag_color = c;
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] depth;
        logic [CW-1:0] color;
        logic [DW-1:0] ram;
        logic          exp_wr;
    } vec_t;

    vec_t vecs [9];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int frag_w, clr_w, addr_err, rdy_err, late_we;
        logic done, found;

        vecs[0] = '{addr: 15'd100,   depth: 16'd50,    color: 12'hABC, ram: 16'h7FFF, exp_wr: 1'b1};
        vecs[1] = '{addr: 15'd20,    depth: 16'd20,    color: 12'h123, ram: 16'd20,   exp_wr: 1'b0};
        vecs[2] = '{addr: 15'd21,    depth: 16'd19,    color: 12'h456, ram: 16'd20,   exp_wr: 1'b1};
        vecs[3] = '{addr: 15'd300,   depth: 16'hFFFD,  color: 12'h789, ram: 16'd5,    exp_wr: 1'b1};
        vecs[4] = '{addr: 15'd301,   depth: 16'd5,     color: 12'h9AB, ram: 16'hFFF6, exp_wr: 1'b0};
        vecs[5] = '{addr: 15'd302,   depth: 16'hFFE0,  color: 12'hCDE, ram: 16'hFFF0, exp_wr: 1'b1};
        vecs[6] = '{addr: 15'd19200, depth: 16'd0,     color: 12'hFFF, ram: 16'h0000, exp_wr: 1'b0};
        vecs[7] = '{addr: 15'd19199, depth: 16'h7FFE,  color: 12'h0F0, ram: 16'h7FFF, exp_wr: 1'b1};
        vecs[8] = '{addr: 15'd0,     depth: 16'h7FFF,  color: 12'h00F, ram: 16'h7FFF, exp_wr: 1'b0};

        rst = 1'b1; fill_en = 1'b1; poke_en = 1'b0; poke_addr = '0; poke_data = '0;
        bus.clear_start = 1'b0;
        drive(1'b0, '0, '0, '0);
        step();
        step();
        rst = 1'b0; fill_en = 1'b0;

        check("rst_zb_we",      64'(bus.zb_we), 64'd0);
        check("rst_fb_we",      64'(bus.fb_we), 64'd0);
        check("rst_clear_busy", 64'(bus.clear_busy), 64'd0);
        check("rst_frag_ready", 64'(bus.frag_ready), 64'd1);
        check("rst_pass_count", 64'(bus.pass_count), 64'd0);
        check("rst_wr_fields",  64'({bus.zb_wr_addr, bus.zb_wr_data, bus.fb_addr, bus.fb_color}), 64'd0);

        // Isolated fragments against a preloaded RAM word
        for (int i = 0; i < 9; i++) begin
            poke_en   = (32'(vecs[i].addr) < FB);
            poke_addr = vecs[i].addr;
            poke_data = vecs[i].ram;
            step();
            poke_en = 1'b0;
            drive(1'b1, vecs[i].addr, vecs[i].depth, vecs[i].color);
            check($sformatf("v%0d_ready", i), 64'(bus.frag_ready), 64'd1);
            step();
            drive(1'b0, '0, '0, '0);
            check($sformatf("v%0d_ready_after", i), 64'(bus.frag_ready), 64'd1);
            step();
            if (vecs[i].exp_wr) exp_pass++;
            check($sformatf("v%0d_zb_we", i), 64'(bus.zb_we), 64'(vecs[i].exp_wr));
            check($sformatf("v%0d_fb_we", i), 64'(bus.fb_we), 64'(vecs[i].exp_wr));
            if (vecs[i].exp_wr) begin
                check($sformatf("v%0d_zb_addr", i), 64'(bus.zb_wr_addr), 64'(vecs[i].addr));
                check($sformatf("v%0d_zb_data", i), 64'(bus.zb_wr_data), 64'(vecs[i].depth));
                check($sformatf("v%0d_fb_addr", i), 64'(bus.fb_addr), 64'(vecs[i].addr));
                check($sformatf("v%0d_fb_color", i), 64'(bus.fb_color), 64'(vecs[i].color));
            end
            check($sformatf("v%0d_pass_count", i), 64'(bus.pass_count), 64'(exp_pass));
            step();
            check($sformatf("v%0d_one_cycle", i), 64'({bus.zb_we, bus.fb_we}), 64'd0);
        end

        // Back-to-back at addr 7: 40, 30, then 35 must lose to the forwarded 30
        drive(1'b1, 15'd7, 16'd40, 12'h111);
        step();
        drive(1'b1, 15'd7, 16'd30, 12'h222);
        step();
        check("b2b_first_we",   64'({bus.zb_we, bus.fb_we}), 64'd3);
        check("b2b_first_data", 64'(bus.zb_wr_data), 64'd40);
        drive(1'b1, 15'd7, 16'd35, 12'h333);
        step();
        check("b2b_second_we",    64'({bus.zb_we, bus.fb_we}), 64'd3);
        check("b2b_second_data",  64'(bus.zb_wr_data), 64'd30);
        check("b2b_second_color", 64'(bus.fb_color), 64'h222);
        drive(1'b0, '0, '0, '0);
        step();
        exp_pass += 2;
        check("b2b_third_rejected", 64'({bus.zb_we, bus.fb_we}), 64'd0);
        check("b2b_pass_count",     64'(bus.pass_count), 64'(exp_pass));

        // One-bubble gap at addr 9: 45 must lose to the write made one cycle earlier
        drive(1'b1, 15'd9, 16'd40, 12'h444);
        step();
        drive(1'b0, '0, '0, '0);
        step();
        check("gap_first_data", 64'({bus.zb_we, bus.zb_wr_data}), 64'h1_0028);
        drive(1'b1, 15'd9, 16'd45, 12'h555);
        step();
        drive(1'b0, '0, '0, '0);
        step();
        exp_pass += 1;
        check("gap_second_rejected", 64'(bus.zb_we), 64'd0);
        check("gap_pass_count",      64'(bus.pass_count), 64'(exp_pass));

        // Clear with two fragments in flight; second one arrives with clear_start
        drive(1'b1, 15'd50, 16'd10, 12'hA0A);
        step();
        drive(1'b1, 15'd51, 16'd11, 12'hB0B);
        bus.clear_start = 1'b1;
        check("clr_same_cycle_ready", 64'(bus.frag_ready), 64'd1);
        step();
        drive(1'b0, '0, '0, '0);
        bus.clear_start = 1'b0;
        check("clr_busy_next",  64'(bus.clear_busy), 64'd1);
        check("clr_ready_drop", 64'(bus.frag_ready), 64'd0);
        frag_w = 0; clr_w = 0; addr_err = 0; rdy_err = 0; done = 1'b0;
        for (int c = 0; c < 25000 && !done; c++) begin
            if (bus.fb_we) frag_w++;
            if (bus.zb_we && !bus.fb_we) begin
                if ((32'(bus.zb_wr_addr) != 32'(clr_w)) || (bus.zb_wr_data != 16'h7FFF)) addr_err++;
                clr_w++;
            end
            if (bus.clear_busy && bus.frag_ready) rdy_err++;
            if (!bus.clear_busy) begin
                done = 1'b1;
            end else begin
                bus.clear_start = (c == 100);
                step();
            end
        end
        bus.clear_start = 1'b0;
        check("clr_finished",    64'(done), 64'd1);
        check("clr_frag_writes", 64'(frag_w), 64'd2);
        check("clr_writes",      64'(clr_w), 64'd19200);
        check("clr_addr_errors", 64'(addr_err), 64'd0);
        check("clr_ready_low",   64'(rdy_err), 64'd0);
        check("clr_pass_count",  64'(bus.pass_count), 64'd0);
        check("clr_ready_back",  64'(bus.frag_ready), 64'd1);
        step();
        check("clr_no_restart",  64'({bus.zb_we, bus.clear_busy}), 64'd0);
        exp_pass = 0;

        // Reset while the clear is writing address 500
        bus.clear_start = 1'b1;
        step();
        bus.clear_start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 1000 && !found; c++) begin
            if (bus.zb_we && (bus.zb_wr_addr == 15'd500)) found = 1'b1;
            else step();
        end
        check("rstclr_reached_500", 64'(found), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstclr_zb_we",      64'(bus.zb_we), 64'd0);
        check("rstclr_clear_busy", 64'(bus.clear_busy), 64'd0);
        check("rstclr_frag_ready", 64'(bus.frag_ready), 64'd1);
        late_we = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (bus.zb_we || bus.fb_we) late_we++;
        end
        check("rstclr_no_writes", 64'(late_we), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
